// File: rtl/pipeline_control_arbiter_pkg.sv
// rtl/pipeline_control_arbiter_pkg.sv - pipeline-control word, arbiter state and helpers
package pipeline_control_arbiter_pkg;

  // One request/response word. Barrier lines gate the inter-stage registers,
  // stage lines freeze whole stages.
  typedef struct packed {
    logic active;
    logic exclusive;
    logic barrier_if_id_reset;
    logic barrier_if_id_stall;
    logic barrier_id_ex_reset;
    logic barrier_id_ex_stall;
    logic barrier_ex_mem_reset;
    logic barrier_ex_mem_stall;
    logic barrier_mem_wb_reset;
    logic barrier_mem_wb_stall;
    logic stage_fetch_stall;
    logic stage_decode_stall;
    logic stage_execute_stall;
    logic stage_mem_stall;
  } lc3b_pipeline_control_word;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } lc3b_pipeline_arb_state;

  function automatic lc3b_pipeline_control_word pipeline_control_zero();
    return '0;
  endfunction

  function automatic logic any_stage_stall(input lc3b_pipeline_control_word w);
    return w.stage_fetch_stall | w.stage_decode_stall | w.stage_execute_stall | w.stage_mem_stall;
  endfunction

  function automatic logic any_barrier_reset(input lc3b_pipeline_control_word w);
    return w.barrier_if_id_reset | w.barrier_id_ex_reset | w.barrier_ex_mem_reset | w.barrier_mem_wb_reset;
  endfunction

endpackage

// File: rtl/pipeline_control_arbiter_merge.sv
// rtl/pipeline_control_arbiter_merge.sv - OR-merge of non-exclusive requests with flush-wins resolution
module pipeline_control_merge
  import pipeline_control_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  lc3b_pipeline_control_word [NUM_REQ-1:0] i_words,
  input  logic [NUM_REQ-1:0]                      i_mask,
  output lc3b_pipeline_control_word               o_word
);

  lc3b_pipeline_control_word w_or;

  // OR every masked word, then let a barrier reset override a stall on the same barrier
  always_comb begin
    w_or = pipeline_control_zero();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_mask[i]) begin
        w_or = w_or | i_words[i];
      end
    end
    o_word = w_or;
    o_word.exclusive = 1'b0;
    if (w_or.barrier_if_id_reset)  o_word.barrier_if_id_stall  = 1'b0;
    if (w_or.barrier_id_ex_reset)  o_word.barrier_id_ex_stall  = 1'b0;
    if (w_or.barrier_ex_mem_reset) o_word.barrier_ex_mem_stall = 1'b0;
    if (w_or.barrier_mem_wb_reset) o_word.barrier_mem_wb_stall = 1'b0;
  end

endmodule

// File: rtl/pipeline_control_arbiter.sv
// rtl/pipeline_control_arbiter.sv - merges hazard requests, grants exclusive locks, counts stalls/flushes
module pipeline_control_arbiter
  import pipeline_control_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int COUNT_W  = 16,
  parameter int LOCK_MAX = 1024,
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  lc3b_pipeline_control_word [NUM_REQ-1:0] requests,
  input  logic                                    clear_counters,
  output lc3b_pipeline_control_word               pipeline_control,
  output logic [NUM_REQ-1:0]                      grant,
  output logic                                    locked,
  output logic [OWNER_W-1:0]                      lock_owner,
  output logic [COUNT_W-1:0]                      stall_cycles,
  output logic [COUNT_W-1:0]                      flush_events,
  output logic                                    lock_timeout
);

  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  lc3b_pipeline_arb_state    r_state;
  lc3b_pipeline_arb_state    w_state_next;
  logic [OWNER_W-1:0]        r_owner;
  logic [OWNER_W-1:0]        w_owner_next;
  logic [NUM_REQ-1:0]        w_valid;
  logic [NUM_REQ-1:0]        w_excl_req;
  logic                      w_excl_found;
  logic [OWNER_W-1:0]        w_excl_idx;
  logic                      w_lock_live;
  lc3b_pipeline_control_word w_merged;
  logic [LOCK_W-1:0]         r_lock_cnt;
  logic [LOCK_W-1:0]         w_lock_cnt_next;
  logic [COUNT_W-1:0]        r_stall_cycles;
  logic [COUNT_W-1:0]        r_flush_events;
  logic                      r_lock_timeout;

  pipeline_control_merge #(
    .NUM_REQ (NUM_REQ)
  ) u_merge (
    .i_words (requests),
    .i_mask  (w_valid),
    .o_word  (w_merged)
  );

  // Split each request into valid and valid-exclusive bits
  always_comb begin
    w_valid    = '0;
    w_excl_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_valid[i]    = requests[i].active;
      w_excl_req[i] = requests[i].active & requests[i].exclusive;
    end
  end

  // State register: arbitration state and current lock owner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
    end
  end

  // Next state: a live owner keeps the lock, otherwise the lowest-index exclusive request takes it
  always_comb begin
    w_excl_found = 1'b0;
    w_excl_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_excl_req[i]) begin
        w_excl_found = 1'b1;
        w_excl_idx   = OWNER_W'(i);
      end
    end
    w_lock_live  = (r_state == ARB_LOCKED) && w_excl_req[r_owner];
    w_state_next = ARB_IDLE;
    w_owner_next = '0;
    if (w_lock_live) begin
      w_state_next = ARB_LOCKED;
      w_owner_next = r_owner;
    end else if (w_excl_found) begin
      w_state_next = ARB_LOCKED;
      w_owner_next = w_excl_idx;
    end
  end

  // Outputs: owner pass-through, new exclusive winner, or the merged word; all forced low in reset
  always_comb begin
    pipeline_control = pipeline_control_zero();
    grant            = '0;
    locked           = 1'b0;
    if (reset_n) begin
      if (w_lock_live) begin
        pipeline_control = requests[r_owner];
        grant[r_owner]   = 1'b1;
        locked           = 1'b1;
      end else if (w_excl_found) begin
        pipeline_control  = requests[w_excl_idx];
        grant[w_excl_idx] = 1'b1;
        locked            = 1'b1;
      end else begin
        pipeline_control = w_merged;
        grant            = w_valid;
      end
    end
  end

  // Watchdog count: the acquiring cycle counts as 1, a held lock adds 1 (saturating), anything else restarts
  always_comb begin
    w_lock_cnt_next = '0;
    if (w_lock_live) begin
      w_lock_cnt_next = (r_lock_cnt == LOCK_W'(LOCK_MAX)) ? r_lock_cnt : r_lock_cnt + LOCK_W'(1);
    end else if (w_excl_found) begin
      w_lock_cnt_next = LOCK_W'(1);
    end
  end

  // Watchdog register and sticky timeout flag; clear beats a new timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_cnt     <= '0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_cnt_next;
      if (clear_counters) begin
        r_lock_timeout <= 1'b0;
      end else if (w_lock_cnt_next == LOCK_W'(LOCK_MAX)) begin
        r_lock_timeout <= 1'b1;
      end
    end
  end

  // Saturating performance counters on the arbitrated word; clear beats increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else if (clear_counters) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (any_stage_stall(pipeline_control) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + COUNT_W'(1);
      end
      if (any_barrier_reset(pipeline_control) && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + COUNT_W'(1);
      end
    end
  end

  assign lock_owner   = r_owner;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
  assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// tb/tb_pipeline_control_arbiter.sv - directed self-checking bench for pipeline_control_arbiter
module tb_pipeline_control_arbiter;
  import pipeline_control_arbiter_pkg::*;

  logic                            clk;
  logic                            reset_n;
  logic                            clear_counters;
  lc3b_pipeline_control_word [3:0] requests;
  lc3b_pipeline_control_word       pipeline_control;
  logic [3:0]                      grant;
  logic                            locked;
  logic [1:0]                      lock_owner;
  logic [7:0]                      stall_cycles;
  logic [7:0]                      flush_events;
  logic                            lock_timeout;

  int checks;
  int errors;

  pipeline_control_arbiter #(
    .NUM_REQ  (4),
    .COUNT_W  (8),
    .LOCK_MAX (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .requests         (requests),
    .clear_counters   (clear_counters),
    .pipeline_control (pipeline_control),
    .grant            (grant),
    .locked           (locked),
    .lock_owner       (lock_owner),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events),
    .lock_timeout     (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    lc3b_pipeline_control_word s;
    s = '0; s.active = 1'b1; s.stage_fetch_stall = 1'b1;
    reset_n = 1'b0; clear_counters = 1'b0; requests = '0; requests[0] = s;
    #2;
    checks++; if (pipeline_control !== 14'h0) begin errors++; $display("FAIL reset_word got %h exp %h", pipeline_control, 14'h0); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    tick();
    checks++; if ({lock_owner, stall_cycles, flush_events, lock_timeout} !== 19'h0) begin errors++; $display("FAIL reset_regs got %h/%h/%h/%b exp 0", lock_owner, stall_cycles, flush_events, lock_timeout); end
    reset_n = 1'b1; requests = '0;
    tick();
  endtask

  task automatic test_merge();
    lc3b_pipeline_control_word r1, r2, e;
    r2 = '0; r2.active = 1'b1; r2.barrier_if_id_stall = 1'b1; r2.barrier_id_ex_stall = 1'b1;
    r2.barrier_ex_mem_reset = 1'b1; r2.stage_fetch_stall = 1'b1; r2.stage_decode_stall = 1'b1;
    r1 = '0; r1.active = 1'b1; r1.barrier_if_id_reset = 1'b1;
    e = '0; e.active = 1'b1; e.barrier_if_id_reset = 1'b1; e.barrier_id_ex_stall = 1'b1;
    e.barrier_ex_mem_reset = 1'b1; e.stage_fetch_stall = 1'b1; e.stage_decode_stall = 1'b1;
    requests = '0; requests[1] = r1; requests[2] = r2;
    #1;
    checks++; if (pipeline_control !== e) begin errors++; $display("FAIL merge_word got %h exp %h", pipeline_control, e); end
    checks++; if (grant !== 4'b0110) begin errors++; $display("FAIL merge_grant got %b exp 0110", grant); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL merge_locked got %b exp 0", locked); end
    tick();
    checks++; if (stall_cycles !== 8'd1) begin errors++; $display("FAIL merge_stall_cnt got %0d exp 1", stall_cycles); end
    checks++; if (flush_events !== 8'd1) begin errors++; $display("FAIL merge_flush_cnt got %0d exp 1", flush_events); end
    requests = '0;
    #1;
    checks++; if (pipeline_control !== 14'h0 || grant !== 4'b0000) begin errors++; $display("FAIL idle_word got %h/%b exp 0/0000", pipeline_control, grant); end
    tick();
    checks++; if (stall_cycles !== 8'd1 || flush_events !== 8'd1) begin errors++; $display("FAIL idle_counts got %0d/%0d exp 1/1", stall_cycles, flush_events); end
  endtask

  task automatic test_lock_no_preempt();
    lc3b_pipeline_control_word x3, x0;
    x3 = '0; x3.active = 1'b1; x3.exclusive = 1'b1; x3.barrier_mem_wb_stall = 1'b1; x3.stage_execute_stall = 1'b1;
    x0 = '0; x0.active = 1'b1; x0.exclusive = 1'b1; x0.barrier_if_id_reset = 1'b1;
    requests = '0; requests[3] = x3;
    #1;
    checks++; if (pipeline_control !== x3 || grant !== 4'b1000 || locked !== 1'b1) begin errors++; $display("FAIL lock_c1 got %h/%b/%b exp %h/1000/1", pipeline_control, grant, locked, x3); end
    checks++; if (lock_owner !== 2'd0) begin errors++; $display("FAIL lock_c1_owner got %0d exp 0", lock_owner); end
    tick();
    requests[0] = x0;
    for (int c = 2; c <= 5; c++) begin
      #1;
      checks++; if (pipeline_control !== x3 || grant !== 4'b1000 || locked !== 1'b1) begin errors++; $display("FAIL lock_c%0d got %h/%b/%b exp %h/1000/1", c, pipeline_control, grant, locked, x3); end
      checks++; if (lock_owner !== 2'd3) begin errors++; $display("FAIL lock_c%0d_owner got %0d exp 3", c, lock_owner); end
      tick();
    end
    requests[3] = '0;
    #1;
    checks++; if (pipeline_control !== x0 || grant !== 4'b0001 || locked !== 1'b1) begin errors++; $display("FAIL handoff got %h/%b/%b exp %h/0001/1", pipeline_control, grant, locked, x0); end
    tick();
    checks++; if (lock_owner !== 2'd0) begin errors++; $display("FAIL handoff_owner got %0d exp 0", lock_owner); end
    requests = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    lc3b_pipeline_control_word x1, x2, n1;
    x1 = '0; x1.active = 1'b1; x1.exclusive = 1'b1; x1.barrier_id_ex_reset = 1'b1;
    x2 = '0; x2.active = 1'b1; x2.exclusive = 1'b1; x2.stage_mem_stall = 1'b1;
    n1 = x1; n1.exclusive = 1'b0;
    requests = '0; requests[1] = x1; requests[2] = x2;
    #1;
    checks++; if (pipeline_control !== x1 || grant !== 4'b0010 || locked !== 1'b1) begin errors++; $display("FAIL simul_win got %h/%b/%b exp %h/0010/1", pipeline_control, grant, locked, x1); end
    tick();
    checks++; if (lock_owner !== 2'd1) begin errors++; $display("FAIL simul_owner got %0d exp 1", lock_owner); end
    requests[1] = n1;
    #1;
    checks++; if (pipeline_control !== x2 || grant !== 4'b0100 || locked !== 1'b1) begin errors++; $display("FAIL simul_release got %h/%b/%b exp %h/0100/1", pipeline_control, grant, locked, x2); end
    tick();
    checks++; if (lock_owner !== 2'd2) begin errors++; $display("FAIL simul_owner2 got %0d exp 2", lock_owner); end
    requests = '0;
    tick();
    checks++; if (lock_owner !== 2'd0) begin errors++; $display("FAIL simul_idle_owner got %0d exp 0", lock_owner); end
  endtask

  task automatic test_saturation();
    lc3b_pipeline_control_word s;
    s = '0; s.active = 1'b1; s.stage_fetch_stall = 1'b1;
    requests = '0; requests[0] = s; clear_counters = 1'b1;
    tick();
    checks++; if (stall_cycles !== 8'd0) begin errors++; $display("FAIL clear_vs_stall got %0d exp 0", stall_cycles); end
    clear_counters = 1'b0;
    repeat (255) tick();
    checks++; if (stall_cycles !== 8'hFF) begin errors++; $display("FAIL sat_reach got %h exp ff", stall_cycles); end
    repeat (3) tick();
    checks++; if (stall_cycles !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h exp ff", stall_cycles); end
    checks++; if (flush_events !== 8'd0) begin errors++; $display("FAIL sat_flush got %0d exp 0", flush_events); end
    clear_counters = 1'b1;
    tick();
    checks++; if (stall_cycles !== 8'd0) begin errors++; $display("FAIL sat_clear got %h exp 00", stall_cycles); end
    clear_counters = 1'b0;
    tick();
    checks++; if (stall_cycles !== 8'd1) begin errors++; $display("FAIL sat_restart got %0d exp 1", stall_cycles); end
    requests = '0;
    tick();
  endtask

  task automatic test_timeout();
    lc3b_pipeline_control_word xt;
    xt = '0; xt.active = 1'b1; xt.exclusive = 1'b1; xt.barrier_ex_mem_stall = 1'b1;
    requests = '0; clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL to_cleared got %b exp 0", lock_timeout); end
    requests[1] = xt;
    repeat (3) tick();
    checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", lock_timeout); end
    tick();
    checks++; if (lock_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", lock_timeout); end
    requests = '0;
    repeat (3) tick();
    checks++; if (lock_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", lock_timeout); end
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", lock_timeout); end
  endtask

  task automatic test_reset_mid_lock();
    lc3b_pipeline_control_word x1, x2;
    x2 = '0; x2.active = 1'b1; x2.exclusive = 1'b1; x2.stage_decode_stall = 1'b1; x2.barrier_mem_wb_reset = 1'b1;
    x1 = '0; x1.active = 1'b1; x1.exclusive = 1'b1; x1.barrier_if_id_stall = 1'b1;
    requests = '0; requests[2] = x2;
    tick();
    checks++; if (lock_owner !== 2'd2 || locked !== 1'b1) begin errors++; $display("FAIL pre_reset got %0d/%b exp 2/1", lock_owner, locked); end
    #2;
    reset_n = 1'b0; requests[1] = x1;
    #1;
    checks++; if (pipeline_control !== 14'h0 || grant !== 4'b0000 || locked !== 1'b0) begin errors++; $display("FAIL mid_reset_out got %h/%b/%b exp 0/0000/0", pipeline_control, grant, locked); end
    checks++; if ({lock_owner, stall_cycles, flush_events, lock_timeout} !== 19'h0) begin errors++; $display("FAIL mid_reset_regs got %h/%h/%h/%b exp 0", lock_owner, stall_cycles, flush_events, lock_timeout); end
    #1;
    reset_n = 1'b1;
    #1;
    checks++; if (pipeline_control !== x1 || grant !== 4'b0010 || locked !== 1'b1) begin errors++; $display("FAIL post_reset got %h/%b/%b exp %h/0010/1", pipeline_control, grant, locked, x1); end
    checks++; if (stall_cycles !== 8'd0 || flush_events !== 8'd0) begin errors++; $display("FAIL post_reset_cnt got %0d/%0d exp 0/0", stall_cycles, flush_events); end
    tick();
    checks++; if (lock_owner !== 2'd1) begin errors++; $display("FAIL post_reset_owner got %0d exp 1", lock_owner); end
    requests = '0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_merge();
    test_lock_no_preempt();
    test_simultaneous();
    test_saturation();
    test_timeout();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
